// File: rtl/tl_timer_pkg.sv
// Shared types and constants for the traffic-light timer bank.
package tl_timer_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE   = 2'd0,
    TMR_RUN    = 2'd1,
    TMR_PAUSED = 2'd2,
    TMR_DONE   = 2'd3
  } tmr_state_t;

  localparam logic TMR_ONESHOT    = 1'b0;
  localparam logic TMR_AUTORELOAD = 1'b1;

  function automatic logic tmr_is_active(input tmr_state_t s);
    return (s == TMR_RUN) || (s == TMR_PAUSED);
  endfunction

endpackage

// File: rtl/tl_timer_ch.sv
// One reloadable down-counter channel: FSM, counter and reload register.
module tl_timer_ch
  import tl_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  input  logic             mode,
  input  logic             pause,
  input  logic             clear,
  output logic             expired,
  output logic             expire_pulse,
  output logic             running,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  tmr_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] reload_r, reload_s;
  logic             mode_r, mode_s;
  logic             pulse_r, pulse_s;
  logic             running_r;

  // Next-state: clear beats load beats pause beats the tick decrement.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    reload_s = reload_r;
    mode_s   = mode_r;
    pulse_s  = 1'b0;
    if (clear) begin
      cnt_s   = CNT_ZERO;
      state_s = TMR_IDLE;
    end else if (load) begin
      mode_s = mode;
      if (val != CNT_ZERO) begin
        cnt_s    = val;
        reload_s = val;
        state_s  = pause ? TMR_PAUSED : TMR_RUN;
      end else begin
        // A zero period expires at once and never re-arms, even in auto-reload.
        cnt_s    = CNT_ZERO;
        reload_s = CNT_ZERO;
        state_s  = TMR_DONE;
        pulse_s  = 1'b1;
      end
    end else begin
      case (state_r)
        TMR_RUN, TMR_PAUSED: begin
          if (pause) begin
            state_s = TMR_PAUSED;
          end else begin
            // Leaving PAUSED counts on the same edge so a pause costs only its own cycles.
            state_s = TMR_RUN;
            if (tick && (cnt_r > CNT_ONE)) begin
              cnt_s = cnt_r - CNT_ONE;
            end else if (tick && (cnt_r == CNT_ONE)) begin
              pulse_s = 1'b1;
              if (mode_r == TMR_AUTORELOAD) begin
                cnt_s = reload_r;
              end else begin
                cnt_s   = CNT_ZERO;
                state_s = TMR_DONE;
              end
            end else begin
              cnt_s = cnt_r;
            end
          end
        end
        TMR_IDLE, TMR_DONE: state_s = state_r;
        default:            state_s = TMR_IDLE;
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= TMR_IDLE;
      cnt_r     <= CNT_ZERO;
      reload_r  <= CNT_ZERO;
      mode_r    <= TMR_ONESHOT;
      pulse_r   <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      reload_r  <= reload_s;
      mode_r    <= mode_s;
      pulse_r   <= pulse_s;
      running_r <= tmr_is_active(state_s);
    end
  end

  assign expired      = (state_r == TMR_IDLE) || (state_r == TMR_DONE);
  assign expire_pulse = pulse_r;
  assign running      = running_r;
  assign remaining    = cnt_r;

endmodule

// File: rtl/tl_timer_bank.sv
// Bank of independent timer channels sharing one free-running prescaler.
module tl_timer_bank
  import tl_timer_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       load,
  input  logic [N_CH*CNT_W-1:0] load_val,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH-1:0]       pause,
  input  logic [N_CH-1:0]       clear,
  output logic [N_CH-1:0]       expired,
  output logic [N_CH-1:0]       expire_pulse,
  output logic [N_CH-1:0]       running,
  output logic [N_CH*CNT_W-1:0] remaining
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  logic [PW-1:0] presc_r;
  logic          tick_s;

  // Loads never restart the prescaler, so tick phase is global.
  assign tick_s = (presc_r == PRE_LAST);

  // Free-running prescaler 0..PRESCALE-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PRE_ONE;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tl_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick_s),
      .load         (load[i]),
      .val          (load_val[i*CNT_W +: CNT_W]),
      .mode         (mode[i]),
      .pause        (pause[i]),
      .clear        (clear[i]),
      .expired      (expired[i]),
      .expire_pulse (expire_pulse[i]),
      .running      (running[i]),
      .remaining    (remaining[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_tl_timer_bank.sv
// Self-checking bench: PRESCALE=1 and PRESCALE=4 banks driven together against a count model.
module tb_tl_timer_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   load, mode, pause, clear;
  logic [127:0] load_val;
  logic [3:0]   xp1, pul1, run1, xp4, pul4, run4;
  logic [127:0] rem1, rem4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_cnt [2][4];
  logic [31:0] m_rel [2][4];
  bit          m_md  [2][4];
  bit          m_act [2][4];
  bit          m_pul [2][4];
  int          m_pc;

  typedef struct {
    logic        ld;
    logic [31:0] v;
    logic [31:0] exp_rem;
    logic        exp_pul;
    logic        exp_xp;
  } vec_t;
  vec_t vec [8];

  always #5 clk = ~clk;

  tl_timer_bank #(.N_CH(4), .CNT_W(32), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .mode(mode),
    .pause(pause), .clear(clear), .expired(xp1), .expire_pulse(pul1),
    .running(run1), .remaining(rem1));

  tl_timer_bank #(.N_CH(4), .CNT_W(32), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .mode(mode),
    .pause(pause), .clear(clear), .expired(xp4), .expire_pulse(pul4),
    .running(run4), .remaining(rem4));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        m_cnt[d][c] = 32'd0; m_rel[d][c] = 32'd0; m_md[d][c] = 1'b0;
        m_act[d][c] = 1'b0;  m_pul[d][c] = 1'b0;
      end
    m_pc = 0;
  endtask

  task automatic model_edge();
    bit tk;
    logic [31:0] v;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        tk = (d == 0) ? 1'b1 : (m_pc == 3);
        v  = load_val[c*32 +: 32];
        m_pul[d][c] = 1'b0;
        if (clear[c]) begin
          m_cnt[d][c] = 32'd0; m_act[d][c] = 1'b0;
        end else if (load[c]) begin
          m_md[d][c] = mode[c];
          if (v != 32'd0) begin
            m_cnt[d][c] = v; m_rel[d][c] = v; m_act[d][c] = 1'b1;
          end else begin
            m_cnt[d][c] = 32'd0; m_act[d][c] = 1'b0; m_pul[d][c] = 1'b1;
          end
        end else if (m_act[d][c] && !pause[c] && tk) begin
          if (m_cnt[d][c] == 32'd1) begin
            m_pul[d][c] = 1'b1;
            if (m_md[d][c]) m_cnt[d][c] = m_rel[d][c];
            else begin m_cnt[d][c] = 32'd0; m_act[d][c] = 1'b0; end
          end else begin
            m_cnt[d][c] = m_cnt[d][c] - 32'd1;
          end
        end
      end
    m_pc = (m_pc + 1) % 4;
  endtask

  task automatic model_check();
    logic [3:0]   e_xp [2], e_pul [2], e_run [2];
    logic [127:0] e_rem [2];
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        e_xp[d][c]  = !m_act[d][c];
        e_run[d][c] = m_act[d][c];
        e_pul[d][c] = m_pul[d][c];
        e_rem[d][c*32 +: 32] = m_cnt[d][c];
      end
    chk("p1_expired", {124'd0, xp1}, {124'd0, e_xp[0]});
    chk("p1_pulse", {124'd0, pul1}, {124'd0, e_pul[0]});
    chk("p1_running", {124'd0, run1}, {124'd0, e_run[0]});
    chk("p1_remaining", rem1, e_rem[0]);
    chk("p4_expired", {124'd0, xp4}, {124'd0, e_xp[1]});
    chk("p4_pulse", {124'd0, pul4}, {124'd0, e_pul[1]});
    chk("p4_running", {124'd0, run4}, {124'd0, e_run[1]});
    chk("p4_remaining", rem4, e_rem[1]);
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later, strobes dropped.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
    load  = 4'd0;
    clear = 4'd0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_expired", {120'd0, xp4, xp1}, {120'd0, 8'hFF});
    chk("rst_pulse", {120'd0, pul4, pul1}, 128'd0);
    chk("rst_running", {120'd0, run4, run1}, 128'd0);
    chk("rst_remaining", rem1 | rem4, 128'd0);
  endtask

  initial begin
    int c;
    bit got;
    rst_n = 1'b0; load = 4'd0; mode = 4'd0; pause = 4'd0; clear = 4'd0;
    load_val = 128'd0;
    model_reset();
    #2;
    chk_reset_vals();
    #10 rst_n = 1'b1;

    // One-shot V=5 on ch0, then a zero load.
    vec[0] = '{1'b1, 32'd5, 32'd5, 1'b0, 1'b0};
    vec[1] = '{1'b0, 32'd0, 32'd4, 1'b0, 1'b0};
    vec[2] = '{1'b0, 32'd0, 32'd3, 1'b0, 1'b0};
    vec[3] = '{1'b0, 32'd0, 32'd2, 1'b0, 1'b0};
    vec[4] = '{1'b0, 32'd0, 32'd1, 1'b0, 1'b0};
    vec[5] = '{1'b0, 32'd0, 32'd0, 1'b1, 1'b1};
    vec[6] = '{1'b0, 32'd0, 32'd0, 1'b0, 1'b1};
    vec[7] = '{1'b1, 32'd0, 32'd0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      load[0] = vec[i].ld;
      load_val[31:0] = vec[i].v;
      step();
      chk($sformatf("vec%0d_rem", i), {96'd0, rem1[31:0]}, {96'd0, vec[i].exp_rem});
      chk($sformatf("vec%0d_pulse", i), {127'd0, pul1[0]}, {127'd0, vec[i].exp_pul});
      chk($sformatf("vec%0d_expired", i), {127'd0, xp1[0]}, {127'd0, vec[i].exp_xp});
    end

    // Auto-reload V=3 on ch1.
    load[1] = 1'b1; mode[1] = 1'b1; load_val[63:32] = 32'd3;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("ar_rem", {96'd0, rem1[63:32]}, {96'd0, 32'd3 - 32'(i % 3)});
      chk("ar_pulse", {127'd0, pul1[1]}, {127'd0, (i > 0) && (i % 3 == 0)});
      chk("ar_running", {127'd0, run1[1]}, 128'd1);
    end
    clear[1] = 1'b1; mode[1] = 1'b0;
    step();
    chk("clr_state", {124'd0, run1[1], xp1[1], pul1[1], 1'b0}, {124'd0, 4'b0100});
    chk("clr_rem", {96'd0, rem1[63:32]}, 128'd0);

    // Pause 4 cycles mid-count on ch2: pulse 14 cycles after load.
    load[2] = 1'b1; load_val[95:64] = 32'd10;
    step();
    c = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      pause[2] = (c >= 3 && c < 7);
      step();
      c++;
      if (pul1[2]) got = 1'b1;
    end
    pause[2] = 1'b0;
    chk("pause_latency", 128'(c), got ? 128'd14 : 128'hDEAD);

    // Reload on the terminal tick discards the expiry; then clear in RUN.
    load[3] = 1'b1; load_val[127:96] = 32'd2;
    step(); step();
    load[3] = 1'b1; load_val[127:96] = 32'd7;
    step();
    chk("ld_term_rem", {96'd0, rem1[127:96]}, 128'd7);
    chk("ld_term_pulse", {127'd0, pul1[3]}, 128'd0);
    clear[3] = 1'b1;
    step();
    chk("clr_run", {125'd0, run1[3], xp1[3], pul1[3]}, {125'd0, 3'b010});
    step();
    chk("clr_nopulse", {127'd0, pul1[3]}, 128'd0);

    // PRESCALE=4: all channels V=2 expire together 5..8 cycles after load.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < t; k++) step();
      load = 4'hF; mode = 4'h0; load_val = {4{32'd2}};
      step();
      c = 0; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        step();
        c++;
        if (pul4 != 4'd0) got = 1'b1;
      end
      chk("p4_all_pulse", {124'd0, pul4}, {124'd0, 4'hF});
      chk("p4_latency_ok", 128'(got && c >= 5 && c <= 8), 128'd1);
    end

    // Asynchronous reset mid-count, no pulse after release.
    load = 4'hF; load_val = {4{32'd20}};
    step();
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals();
    #2 rst_n = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if ((pul1 | pul4) != 4'd0) got = 1'b1;
    end
    chk("no_pulse_after_rst", 128'(got), 128'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 9) == 0) pause[k] = ~pause[k];
        if ($urandom_range(0, 7) == 0) begin
          load[k] = 1'b1;
          mode[k] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 15) == 0) load_val[k*32 +: 32] = 32'hFFFF_FFFF;
          else load_val[k*32 +: 32] = 32'($urandom_range(0, 6));
        end
        if ($urandom_range(0, 19) == 0) clear[k] = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
